// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the core data bus.
// Register window at BASE_ADDR: TXDATA, STATUS, DIV, reserved.
module uart_tx_mmio #(
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] DIV_RESET  = 16'd16
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] address,
   input  logic [31:0] wdata,
   input  logic [3:0]  byte_enable,
   input  logic        we,
   output logic        hit,
   output logic [31:0] rdata,
   output logic        tx
);

   localparam int         AW    = $clog2(FIFO_DEPTH);
   localparam logic [4:0] DEPTH = 5'(FIFO_DEPTH);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic [1:0]    state;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [4:0]    count;
   logic          overflow;
   logic [15:0]   div;
   logic [15:0]   frame_div;
   logic [15:0]   bit_cnt;
   logic [7:0]    shift;
   logic [2:0]    bit_idx;

   logic [1:0]    offset;
   logic          wr_tx;
   logic          wr_stat;
   logic          wr_div;
   logic          full;
   logic          empty;
   logic          busy;
   logic          pop;
   logic          push;
   logic          bit_done;
   logic [15:0]   div_eff;
   logic          unused_bits;

   assign hit      = address[31:4] == BASE_ADDR[31:4];
   assign offset   = address[3:2];
   assign wr_tx    = we && hit && offset == 2'd0 && byte_enable[0];
   assign wr_stat  = we && hit && offset == 2'd1 && byte_enable[0]
                     && wdata[3];
   assign wr_div   = we && hit && offset == 2'd2;
   assign full     = count == DEPTH;
   assign empty    = count == 5'd0;
   assign busy     = state != IDLE;
   assign pop      = state == IDLE && !empty;
   // A full FIFO still accepts a byte when the head leaves this cycle.
   assign push     = wr_tx && (!full || pop);
   assign div_eff  = (div == 16'd0) ? 16'd1 : div;
   assign bit_done = bit_cnt == 16'd0;

   assign unused_bits = ^{address[1:0], wdata[31:16], byte_enable[3:2]};

   always_comb begin
      rdata = '0;
      if (hit) begin
         case (offset)
            2'd1:    rdata = {23'd0, count, overflow, busy, empty, full};
            2'd2:    rdata = {16'd0, div};
            default: rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            mem[wptr] <= wdata[7:0];
            wptr      <= wptr + AW'(1);
         end
         if (pop)
            rptr <= rptr + AW'(1);
         if (push && !pop)
            count <= count + 5'd1;
         else if (pop && !push)
            count <= count - 5'd1;
         if (wr_tx && !push)
            overflow <= 1'b1;
         else if (wr_stat)
            overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         div <= DIV_RESET;
      end else if (wr_div) begin
         if (byte_enable[0])
            div[7:0] <= wdata[7:0];
         if (byte_enable[1])
            div[15:8] <= wdata[15:8];
      end
   end

   // Divisor is captured per frame so DIV writes only affect later bytes.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= IDLE;
         shift     <= '0;
         bit_idx   <= '0;
         bit_cnt   <= '0;
         frame_div <= 16'd1;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  shift     <= mem[rptr];
                  frame_div <= div_eff;
                  bit_cnt   <= div_eff - 16'd1;
                  state     <= START;
               end
            end
            START: begin
               if (bit_done) begin
                  bit_cnt <= frame_div - 16'd1;
                  bit_idx <= 3'd0;
                  state   <= DATA;
               end else begin
                  bit_cnt <= bit_cnt - 16'd1;
               end
            end
            DATA: begin
               if (bit_done) begin
                  bit_cnt <= frame_div - 16'd1;
                  shift   <= {1'b0, shift[7:1]};
                  if (bit_idx == 3'd7)
                     state <= STOP;
                  else
                     bit_idx <= bit_idx + 3'd1;
               end else begin
                  bit_cnt <= bit_cnt - 16'd1;
               end
            end
            STOP: begin
               if (bit_done)
                  state <= IDLE;
               else
                  bit_cnt <= bit_cnt - 16'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      tx = 1'b1;
      case (state)
         START:   tx = 1'b0;
         DATA:    tx = shift[0];
         default: tx = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register map, framing, FIFO
// overflow, address decode, mid-frame reset and per-frame divisor.
module tb_uart_tx_mmio;

   localparam logic [31:0] BASE = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] address;
   logic [31:0] wdata;
   logic [3:0]  byte_enable;
   logic        we;
   logic        hit;
   logic [31:0] rdata;
   logic        tx;

   int          errors = 0;
   int          checks = 0;
   int          mon_div = 16;
   bit          mon_en = 1'b0;
   int          mon_ferr = 0;
   logic [7:0]  rx_q[$];

   uart_tx_mmio dut (
      .clk         (clk),
      .resetn      (resetn),
      .address     (address),
      .wdata       (wdata),
      .byte_enable (byte_enable),
      .we          (we),
      .hit         (hit),
      .rdata       (rdata),
      .tx          (tx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be);
      address     = a;
      wdata       = d;
      byte_enable = be;
      we          = 1'b1;
      tick();
      we          = 1'b0;
      byte_enable = 4'h0;
   endtask

   task automatic rd(input logic [31:0] a, input string tag,
                     input logic [31:0] exp);
      address = a;
      #1;
      chk(tag, rdata, exp);
   endtask

   // Expected line level at cycle i of a frame carrying b at div cycles/bit.
   function automatic logic frame_bit(input logic [7:0] b, input int dv,
                                      input int i);
      int j;
      j = i / dv;
      if (j == 0)
         return 1'b0;
      if (j >= 9)
         return 1'b1;
      return b[j-1];
   endfunction

   // Line receiver: samples each bit near its centre.
   initial begin
      logic [7:0] b;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en && tx === 1'b0) begin
            repeat (mon_div / 2) begin @(posedge clk); #1; end
            if (tx !== 1'b0) mon_ferr++;
            for (int j = 0; j < 8; j++) begin
               repeat (mon_div) begin @(posedge clk); #1; end
               b[j] = tx;
            end
            repeat (mon_div) begin @(posedge clk); #1; end
            if (tx !== 1'b1) mon_ferr++;
            rx_q.push_back(b);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] burst [5];
      int n;
      int lows;
      burst = '{8'h3C, 8'hF0, 8'h01, 8'h80, 8'h5A};
      address     = '0;
      wdata       = '0;
      byte_enable = '0;
      we          = 1'b0;
      resetn      = 1'b0;
      tick();
      tick();
      resetn = 1'b1;

      chk("reset_tx", tx, 1);
      rd(BASE + 4, "reset_status", 32'h2);
      chk("reset_hit", hit, 1);
      rd(BASE + 8, "reset_div", 32'h10);

      wr(BASE + 8, 32'h4, 4'b0011);
      rd(BASE + 8, "div4", 32'h4);
      wr(BASE, 32'hA5, 4'b0001);
      chk("a5_pre", tx, 1);
      address = BASE + 4;
      for (int i = 0; i < 40; i++) begin
         tick();
         chk($sformatf("a5_bit%0d", i), tx, frame_bit(8'hA5, 4, i));
         if (i == 20)
            chk("a5_busy", rdata[2], 1);
      end
      tick();
      chk("a5_idle", tx, 1);
      rd(BASE + 4, "a5_done", 32'h2);

      mon_div = 16;
      mon_en  = 1'b1;
      wr(BASE + 8, 32'h10, 4'b0011);
      for (int i = 0; i < 5; i++)
         wr(BASE, {24'd0, burst[i]}, 4'b0001);
      rd(BASE + 4, "burst_status", 32'h45);
      wr(BASE, 32'hE7, 4'b0001);
      rd(BASE + 4, "ovf_status", 32'h4D);
      wr(BASE + 4, 32'h8, 4'b0001);
      rd(BASE + 4, "ovf_clear", 32'h45);
      address = BASE + 4;
      n = 0;
      while (rdata !== 32'h2 && n < 3000) begin
         tick();
         n++;
      end
      chk("drain_timeout", n < 3000, 1);
      repeat (20) tick();
      mon_en = 1'b0;
      chk("rx_count", rx_q.size(), 5);
      for (int i = 0; i < 5; i++)
         if (i < rx_q.size())
            chk($sformatf("rx_byte%0d", i), rx_q[i], burst[i]);
      chk("frame_err", mon_ferr, 0);

      rd(BASE + 16, "oor_hi", 32'h0);
      chk("oor_hi_hit", hit, 0);
      rd(BASE - 4, "oor_lo", 32'h0);
      chk("oor_lo_hit", hit, 0);
      rd(BASE + 32'h14, "oor_status", 32'h0);
      rd(BASE + 32'h18, "oor_div", 32'h0);
      wr(BASE + 16, 32'h77, 4'hF);
      wr(BASE - 4, 32'h77, 4'hF);
      wr(BASE + 32'h18, 32'h3, 4'hF);
      rd(BASE + 4, "oor_fifo", 32'h2);
      rd(BASE + 8, "oor_div_kept", 32'h10);
      rd(BASE + 12, "reg12", 32'h0);
      chk("reg12_hit", hit, 1);
      wr(BASE + 12, 32'hFFFF_FFFF, 4'hF);
      rd(BASE + 4, "reg12_fifo", 32'h2);
      rd(BASE + 8, "reg12_div", 32'h10);
      chk("oor_tx", tx, 1);

      wr(BASE + 8, 32'h4, 4'b0011);
      wr(BASE, 32'h11, 4'b0001);
      wr(BASE, 32'h22, 4'b0001);
      wr(BASE, 32'h33, 4'b0001);
      wr(BASE, 32'h44, 4'b0001);
      rd(BASE + 4, "rst_pre", 32'h34);
      repeat (5) tick();
      chk("rst_mid_data", tx, frame_bit(8'h11, 4, 7));
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      chk("rst_tx", tx, 1);
      rd(BASE + 4, "rst_status", 32'h2);
      rd(BASE + 8, "rst_div", 32'h10);
      lows = 0;
      repeat (200) begin
         tick();
         if (tx !== 1'b1) lows++;
      end
      chk("rst_silent", lows, 0);

      wr(BASE + 8, 32'h8, 4'b0011);
      wr(BASE, 32'hC3, 4'b0001);
      wr(BASE, 32'h96, 4'b0001);
      chk("d8_bit0", tx, frame_bit(8'hC3, 8, 0));
      wr(BASE + 8, 32'h2, 4'b0011);
      chk("d8_bit1", tx, frame_bit(8'hC3, 8, 1));
      for (int i = 2; i < 80; i++) begin
         tick();
         chk($sformatf("d8_bit%0d", i), tx, frame_bit(8'hC3, 8, i));
      end
      tick();
      chk("d8_gap", tx, 1);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk($sformatf("d2_bit%0d", i), tx, frame_bit(8'h96, 2, i));
      end
      tick();
      chk("d2_idle", tx, 1);
      rd(BASE + 4, "d2_status", 32'h2);
      rd(BASE + 8, "d2_div", 32'h2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
